// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: per-boundary run/bubble/stall/flush codes.
// Optional cycle counter built only when PIPE_HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int NSTG    = 4,
    parameter int MC_STG  = 2,
    parameter int MEM_STG = 3,
    parameter int OPW     = 6,
    parameter int MC_MAX  = 32,
    localparam int LENW   = $clog2(MC_MAX + 1),
    localparam int SW     = (NSTG > 1) ? $clog2(NSTG) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pval,
    input  logic [OPW-1:0]    opcode,
    input  logic              mc_start,
    input  logic [LENW-1:0]   mc_len,
    input  logic [NSTG-1:0]   exc,
    input  logic              mem_full,
    output logic [2*NSTG-1:0] ctr,
    output logic              exc_valid,
    output logic [SW-1:0]     exc_stg,
    output logic [OPW-1:0]    exc_op,
    output logic              mc_busy,
    output logic [31:0]       stall_cycles
);

    typedef enum logic [1:0] {RUN, MC_WAIT, FLUSH} state_t;

    state_t            state, state_n;
    logic [LENW-1:0]   cnt, cnt_n;
    logic [LENW-1:0]   len_sat;
    logic [2*NSTG-1:0] ctr_n;
    logic              ev_n;
    logic [SW-1:0]     stg_n, top;
    logic [OPW-1:0]    op_n;
    logic              mc_go;
    logic              stall_en;
    int                sp;

    assign len_sat = (mc_len > LENW'(MC_MAX)) ? LENW'(MC_MAX) : mc_len;
    assign mc_go   = (state == RUN) && mc_start && (len_sat >= LENW'(2));

    // Next state, countdown and next boundary codes by priority
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ctr_n    = '0;
        ev_n     = 1'b0;
        stg_n    = exc_stg;
        op_n     = exc_op;
        top      = '0;
        stall_en = 1'b0;
        sp       = 0;
        for (int i = 0; i < NSTG; i++) begin
            if (exc[i]) top = SW'(i);
        end
        case (state)
            FLUSH: begin
                for (int i = 0; i < NSTG; i++) ctr_n[2*i +: 2] = 2'b01;
                state_n = RUN;
                cnt_n   = '0;
            end
            default: begin
                if (|exc) begin
                    for (int i = 0; i < NSTG; i++) begin
                        if (i <= int'(top)) ctr_n[2*i +: 2] = 2'b11;
                    end
                    state_n = FLUSH;
                    cnt_n   = '0;
                    ev_n    = 1'b1;
                    stg_n   = top;
                    op_n    = opcode;
                end else begin
                    if (mc_go) begin
                        cnt_n   = len_sat - LENW'(1);
                        state_n = MC_WAIT;
                    end else if (state == MC_WAIT) begin
                        if (cnt <= LENW'(1)) begin
                            cnt_n   = '0;
                            state_n = RUN;
                        end else begin
                            cnt_n = cnt - LENW'(1);
                        end
                    end
                    if (mem_full) begin
                        stall_en = 1'b1;
                        sp       = MEM_STG;
                    end else if (state_n == MC_WAIT) begin
                        stall_en = 1'b1;
                        sp       = MC_STG;
                    end
                    for (int i = 0; i < NSTG; i++) begin
                        if (stall_en && i < sp)
                            ctr_n[2*i +: 2] = 2'b10;
                        else if (stall_en && i == sp)
                            ctr_n[2*i +: 2] = 2'b01;
                        else if (!stall_en && !pval && i == 1)
                            ctr_n[2*i +: 2] = 2'b01;
                    end
                end
            end
        endcase
    end

    // State, countdown and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= '0;
            ctr       <= '0;
            exc_valid <= 1'b0;
            exc_stg   <= '0;
            exc_op    <= '0;
            mc_busy   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ctr       <= ctr_n;
            exc_valid <= ev_n;
            exc_stg   <= stg_n;
            exc_op    <= op_n;
            mc_busy   <= (state_n == MC_WAIT);
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic stall_now;

    // Any boundary currently held
    always_comb begin
        stall_now = 1'b0;
        for (int i = 0; i < NSTG; i++) begin
            if (ctr[2*i +: 2] == 2'b10) stall_now = 1'b1;
        end
    end

    // Saturating count of held cycles
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall_now && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl.
// Directed vectors push expectations; a negedge monitor pops and checks.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst, pval, mc_start, mem_full;
    logic [5:0]  opcode, mc_len;
    logic [3:0]  exc;
    logic [7:0]  ctr;
    logic        exc_valid, mc_busy;
    logic [1:0]  exc_stg;
    logic [5:0]  exc_op;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst), .pval(pval), .opcode(opcode),
        .mc_start(mc_start), .mc_len(mc_len), .exc(exc),
        .mem_full(mem_full), .ctr(ctr), .exc_valid(exc_valid),
        .exc_stg(exc_stg), .exc_op(exc_op), .mc_busy(mc_busy),
        .stall_cycles(stall_cycles)
    );

    typedef struct {
        int          id;
        logic [7:0]  ctr;
        logic        ev;
        logic [1:0]  stg;
        logic        chk_stg;
        logic [5:0]  op;
        logic        busy;
        logic [31:0] perf;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int sid = 0;
    logic [5:0]  opv = 6'd1;
    logic [31:0] run_perf = 0;

    localparam logic [7:0] P_MC  = 8'b00_01_10_10;
    localparam logic [7:0] P_MEM = 8'b01_10_10_10;
    localparam logic [7:0] P_PV  = 8'b00_00_01_00;
    localparam logic [7:0] P_BUB = 8'b01_01_01_01;

    function automatic logic has_stall(input logic [7:0] c);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) if (c[2*i +: 2] == 2'b10) r = 1'b1;
        return r;
    endfunction

    task automatic chk(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h want %0h", nm, id, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic pv, input logic ms,
                        input logic [5:0] ln, input logic [3:0] e,
                        input logic mf, input logic [7:0] ectr,
                        input logic ev, input logic [1:0] es,
                        input logic eb);
        exp_t x;
        rst = r; pval = pv; mc_start = ms; mc_len = ln;
        exc = e; mem_full = mf; opcode = opv;
        @(posedge clk);
        if (r) run_perf = 0;
        x.id = sid; x.ctr = ectr; x.ev = ev; x.stg = es;
        x.chk_stg = ev | r; x.op = opv; x.busy = eb;
        x.perf = run_perf;
        run_perf = run_perf + {31'd0, has_stall(ectr)};
        q.push_back(x);
        sid++;
        opv = opv + 6'd5;
        #1;
    endtask

    task automatic idle(input logic [7:0] ectr, input logic eb);
        step(0, 1, 0, 6'd0, 4'd0, 0, ectr, 0, 2'd0, eb);
    endtask

    // Monitor: outputs are presented every cycle; compare at negedge
    always @(negedge clk) begin
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("ctr", x.id, {24'd0, ctr}, {24'd0, x.ctr});
            chk("exc_valid", x.id, {31'd0, exc_valid}, {31'd0, x.ev});
            chk("mc_busy", x.id, {31'd0, mc_busy}, {31'd0, x.busy});
            if (x.chk_stg)
                chk("exc_stg", x.id, {30'd0, exc_stg}, {30'd0, x.stg});
            if (x.ev)
                chk("exc_op", x.id, {26'd0, exc_op}, {26'd0, x.op});
`ifdef PIPE_HAZARD_PERF_EN
            chk("stall_cycles", x.id, stall_cycles, x.perf);
`else
            chk("stall_cycles", x.id, stall_cycles, 32'd0);
`endif
        end
    end

    initial begin
        // reset, then quiet pipeline
        step(1, 1, 0, 6'd0, 4'd0, 0, 8'h00, 0, 2'd0, 0);
        step(1, 1, 0, 6'd0, 4'd0, 0, 8'h00, 0, 2'd0, 0);
        for (int i = 0; i < 10; i++) idle(8'h00, 0);
        // front end idle
        step(0, 0, 0, 6'd0, 4'd0, 0, P_PV, 0, 2'd0, 0);
        idle(8'h00, 0);
        // L=4 multi-cycle, second start ignored
        step(0, 1, 1, 6'd4, 4'd0, 0, P_MC, 0, 2'd0, 1);
        step(0, 1, 1, 6'd4, 4'd0, 0, P_MC, 0, 2'd0, 1);
        idle(P_MC, 1);
        idle(8'h00, 0);
        idle(8'h00, 0);
        // exception during MC wait, exc in FLUSH ignored
        step(0, 1, 1, 6'd4, 4'd0, 0, P_MC, 0, 2'd0, 1);
        step(0, 1, 0, 6'd0, 4'b0110, 0, 8'b00_11_11_11, 1, 2'd2, 0);
        step(0, 1, 0, 6'd0, 4'b0001, 0, P_BUB, 0, 2'd0, 0);
        idle(8'h00, 0);
        // mem_full overlapping MC wait; countdown expires underneath
        step(0, 1, 1, 6'd4, 4'd0, 0, P_MC, 0, 2'd0, 1);
        step(0, 1, 0, 6'd0, 4'd0, 1, P_MEM, 0, 2'd0, 1);
        step(0, 1, 0, 6'd0, 4'd0, 1, P_MEM, 0, 2'd0, 1);
        step(0, 1, 0, 6'd0, 4'd0, 1, P_MEM, 0, 2'd0, 0);
        step(0, 1, 0, 6'd0, 4'd0, 1, P_MEM, 0, 2'd0, 0);
        step(0, 1, 0, 6'd0, 4'd0, 1, P_MEM, 0, 2'd0, 0);
        idle(8'h00, 0);
        // reset mid-wait
        step(0, 1, 1, 6'd10, 4'd0, 0, P_MC, 0, 2'd0, 1);
        idle(P_MC, 1);
        step(1, 1, 0, 6'd0, 4'd0, 0, 8'h00, 0, 2'd0, 0);
        idle(8'h00, 0);
        // short lengths
        step(0, 1, 1, 6'd0, 4'd0, 0, 8'h00, 0, 2'd0, 0);
        step(0, 1, 1, 6'd1, 4'd0, 0, 8'h00, 0, 2'd0, 0);
        step(0, 1, 1, 6'd2, 4'd0, 0, P_MC, 0, 2'd0, 1);
        idle(8'h00, 0);
        // length saturates to 32 -> 31 wait cycles
        step(0, 1, 1, 6'd40, 4'd0, 0, P_MC, 0, 2'd0, 1);
        for (int i = 0; i < 30; i++) idle(P_MC, 1);
        idle(8'h00, 0);
        // oldest exception wins
        step(0, 1, 0, 6'd0, 4'b1001, 0, 8'hFF, 1, 2'd3, 0);
        idle(P_BUB, 0);
        idle(8'h00, 0);
        // exception beats mc_start
        step(0, 1, 1, 6'd4, 4'b0001, 0, 8'b00_00_00_11, 1, 2'd0, 0);
        idle(P_BUB, 0);
        idle(8'h00, 0);
        // mem_full beats !pval
        step(0, 0, 0, 6'd0, 4'd0, 1, P_MEM, 0, 2'd0, 0);
        step(0, 0, 0, 6'd0, 4'd0, 0, P_PV, 0, 2'd0, 0);
        idle(8'h00, 0);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d left want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised pipeline control unit. It drives a 2-bit control code onto each of NSTG inter-stage pipeline registers, resolving multi-cycle operations, memory back-pressure (LSQ full), per-stage exceptions and pipeline-idle into run/bubble/stall/flush commands. It generalises the fixed 4-register controller to any stage count and adds real multi-cycle tracking, exception flush with oldest-first priority, and registered status.

## Interface
- NSTG, 4, number of pipeline registers; boundary 0 = IF/ID, boundary NSTG-1 = last (MEM/WB)
- MC_STG, 2, boundary that receives a bubble while a multi-cycle op is in progress
- MEM_STG, 3, boundary that receives a bubble while mem_full is high
- OPW, 6, opcode width
- MC_MAX, 32, maximum multi-cycle latency; LENW = $clog2(MC_MAX+1)

Ports:
- clk  in  1  clock; all state on posedge
- rst  in  1  reset, synchronous, active-high
- pval  in  1  pipeline valid; 0 = front end idle
- opcode  in  OPW  opcode at ID; mirrored to status only
- mc_start  in  1  multi-cycle op enters the EX stage this cycle
- mc_len  in  LENW  total cycles of that op
- exc  in  NSTG  exception raised by the stage feeding boundary i
- mem_full  in  1  LSQ full
- ctr  out  2*NSTG  code for boundary i at bits [2i+1:2i]: 00 run, 01 bubble, 10 stall (hold), 11 flush
- exc_valid  out  1  one-cycle pulse: exception accepted
- exc_stg  out  $clog2(NSTG)  index of the accepted exception
- exc_op  out  OPW  opcode sampled with the exception
- mc_busy  out  1  multi-cycle countdown active
- stall_cycles  out  32  performance counter (see Configuration)

## Operation
- FSM states: RUN, MC_WAIT, FLUSH.
- Stall point s:
  - boundaries 0..s-1 get 10 (stall);
  - boundary s gets 01 (bubble);
  - boundaries above s get 00.
- Priority, evaluated each cycle: rst > exc > mem_full > MC_WAIT > !pval > normal.
- Exception:
  - The highest set index k of exc wins; older stages are deeper.
  - Boundaries 0..k get 11 (flush), boundaries above k get 00.
  - exc_valid=1, exc_stg=k, exc_op=opcode.
  - FSM goes to FLUSH and any MC_WAIT is aborted (counter cleared).
- FLUSH:
  - Lasts one cycle. Every boundary gets 01 (bubble) so the refetched path enters clean.
  - New exc in FLUSH is ignored.
  - Next state is RUN.
- mem_full: stall point s=MEM_STG.
- MC_WAIT: stall point s=MC_STG.
  - When mem_full and MC_WAIT are both active, the mem_full pattern is driven and the counter keeps decrementing.
- !pval, nothing else active: boundary 1 gets 01, all others 00.
- Multi-cycle ops:
  - mc_start is accepted only in RUN.
  - mc_len ≤ 1: no stall.
  - mc_len = L ≥ 2: counter loads L-1, FSM goes to MC_WAIT, mc_busy=1.
  - The counter decrements each cycle. At count 1 the FSM returns to RUN on the next edge.
  - mc_start is ignored in MC_WAIT and FLUSH.
  - mc_len > MC_MAX saturates to MC_MAX.
- Reset values: ctr=0, exc_valid=0, exc_stg=0, exc_op=0, mc_busy=0, counter=0, stall_cycles=0, state RUN.
- rst mid-MC_WAIT or mid-FLUSH returns to RUN on the same edge.

## Timing
- All outputs are registered. Inputs sampled at edge N appear on ctr after edge N, usable by pipeline registers at edge N+1.
- mc_start with L=4 at edge N:
  - MC_WAIT pattern is driven for edges N..N+2 (3 cycles);
  - run is driven after edge N+3.
- An exception produces exactly one flush cycle, then one all-bubble cycle, then RUN.
- exc_valid is high for exactly one cycle per accepted exception.
- exc together with mc_start in the same cycle: exc wins, and mc_start is dropped.

## Configuration
- PIPE_HAZARD_PERF_EN defined: stall_cycles counts every cycle in which any boundary code is 10.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst.
- Not defined: stall_cycles is tied to 0 and no counter logic is built. All other behaviour is identical.

## Test plan
- Reset with pval=1 and all other inputs 0 -> ctr=0, mc_busy=0, exc_valid=0, and they stay so after 10 idle cycles.
- pval=0 -> ctr=8'b00_00_01_00 on the next cycle; pval back to 1 -> ctr=0.
- mc_start, mc_len=4 -> ctr=8'b00_01_10_10 for exactly 3 cycles with mc_busy=1, then 0. A second mc_start during the wait is ignored.
- exc=4'b0110 during MC_WAIT:
  - next cycle ctr=8'b00_11_11_11, exc_valid=1, exc_stg=2, mc_busy=0;
  - then ctr=8'b01_01_01_01 for one cycle;
  - then 0.
- mem_full high 5 cycles with MC_WAIT active -> ctr=8'b01_10_10_10 for 5 cycles.
  - The countdown keeps running and expires during the stall, so there is no residual MC stall.
  - With PIPE_HAZARD_PERF_EN defined, stall_cycles increases by the count of stall cycles.
- rst asserted mid-MC_WAIT -> next cycle all outputs are at reset values. mc_len=0 and mc_len=1 produce no stall.
